wb_reg_file: RTL and testbench

Write-back stage and architectural register file of the five-stage MIPS pipeline. Sits on the consuming side of the MEM/WB pipeline register: it selects the write-back value (memory load data or ALU result), commits it into a 32 x 32-bit register file, and serves two combinational read ports to the ID stage. It also drives a registered commit trace and a commit counter for debug and difftest comparison.

---
 rtl/wb_reg_file_pkg.sv | 9 +
 rtl/wb_reg_array.sv | 51 +++++
 rtl/wb_reg_file.sv | 107 ++++++++++
 tb/tb_wb_reg_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_file_pkg.sv
// Shared sizing constants for the write-back stage and architectural register file.
// Imported by wb_reg_array and wb_reg_file.
package wb_reg_file_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int REG_NUM     = 32;
  localparam int REG_IDX_W   = $clog2(REG_NUM);

endpackage

// File: rtl/wb_reg_array.sv
// 32 x 32 architectural register storage: one write port, two combinational
// read ports, register 0 hard-wired to zero, asynchronous active-high reset.
module wb_reg_array
  import wb_reg_file_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int NUM    = REG_NUM,
  parameter int IDX_W  = REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NUM];
  logic [DATA_W-1:0] regs_d [NUM];

  // NOTE: every always_comb output gets a full default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // NOTE: this storage is architectural state that must read as zero right
  // after reset, so every entry sits on the asynchronous reset rather than
  // being left uninitialised like a plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/wb_reg_file.sv
// MIPS write-back stage: selects the write-back value, commits it to the
// register file, serves two read ports, and emits a registered commit trace
// plus commit counter. Optional same-cycle write bypass: define WB_BYPASS_EN.
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int NUM    = REG_NUM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    W_MEM_mem_data_o,
  input  logic [DATA_W-1:0]    W_MEM_alu_res_o,
  input  logic [REG_IDX_W-1:0] W_MEM_rd_o,
  input  logic                 W_MEM_w_reg_ena_o,
  input  logic                 W_MEM_wb_sel_o,
  input  logic [DATA_W-1:0]    W_MEM_PC_o,
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [REG_IDX_W-1:0] rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic [DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]    debug_wb_pc,
  output logic                 debug_wb_rf_wen,
  output logic [REG_IDX_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata,
  output logic [DATA_W-1:0]    commit_cnt
);

  logic                 wq;
  logic [DATA_W-1:0]    arr_rs;
  logic [DATA_W-1:0]    arr_rt;

  logic [DATA_W-1:0]    pc_q,    pc_d;
  logic                 wen_q,   wen_d;
  logic [REG_IDX_W-1:0] wnum_q,  wnum_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    commit_cnt_q, commit_cnt_d;

  always_comb begin
    wb_data = W_MEM_wb_sel_o ? W_MEM_mem_data_o : W_MEM_alu_res_o;
    // Writes aimed at r0 are dropped entirely: no storage, trace or count.
    wq      = W_MEM_w_reg_ena_o && (W_MEM_rd_o != '0);
  end

  wb_reg_array #(
    .DATA_W (DATA_W),
    .NUM    (NUM),
    .IDX_W  (REG_IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (wq),
    .waddr   (W_MEM_rd_o),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (arr_rs),
    .rdata_b (arr_rt)
  );

  always_comb begin
`ifdef WB_BYPASS_EN
    // Write-before-read: wq already excludes r0, so index 0 still reads zero.
    rs_data = (wq && (rs_addr == W_MEM_rd_o)) ? wb_data : arr_rs;
    rt_data = (wq && (rt_addr == W_MEM_rd_o)) ? wb_data : arr_rt;
`else
    rs_data = arr_rs;
    rt_data = arr_rt;
`endif
  end

  always_comb begin
    pc_d         = W_MEM_PC_o;
    wen_d        = wq;
    wnum_d       = W_MEM_rd_o;
    wdata_d      = wb_data;
    // A held (stalled) instruction is counted again every cycle it sits in WB.
    commit_cnt_d = commit_cnt_q;
    if (wq) begin
      commit_cnt_d = commit_cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      wen_q        <= 1'b0;
      wnum_q       <= '0;
      wdata_q      <= '0;
      commit_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      wen_q        <= wen_d;
      wnum_q       <= wnum_d;
      wdata_q      <= wdata_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = wen_q;
  assign debug_wb_rf_wnum  = wnum_q;
  assign debug_wb_rf_wdata = wdata_q;
  assign commit_cnt        = commit_cnt_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed cases then random traffic
// compared against an array-based reference model; honours WB_BYPASS_EN.
module tb_wb_reg_file;

  logic        clk;
  logic        rst;
  logic [31:0] mem_data, alu_res, pc;
  logic [4:0]  rd, rs_addr, rt_addr;
  logic        ena, sel;
  logic [31:0] rs_data, rt_data, wb_data;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, commit_cnt;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt, m_pc, m_wdata;
  logic        m_wen;
  logic [4:0]  m_wnum;

  wb_reg_file dut (
    .clk               (clk),
    .rst               (rst),
    .W_MEM_mem_data_o  (mem_data),
    .W_MEM_alu_res_o   (alu_res),
    .W_MEM_rd_o        (rd),
    .W_MEM_w_reg_ena_o (ena),
    .W_MEM_wb_sel_o    (sel),
    .W_MEM_PC_o        (pc),
    .rs_addr           (rs_addr),
    .rt_addr           (rt_addr),
    .rs_data           (rs_data),
    .rt_data           (rt_data),
    .wb_data           (wb_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .commit_cnt        (commit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0; m_pc = 0; m_wdata = 0; m_wen = 0; m_wnum = 0;
  endtask

  function automatic logic [31:0] m_wb();
    return sel ? mem_data : alu_res;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (ena && rd != 5'd0 && idx == rd) return m_wb();
`endif
    return m_regs[idx];
  endfunction

  task automatic drive(input logic s, input logic [31:0] md, input logic [31:0] ar,
                       input logic [4:0] d, input logic e, input logic [31:0] p,
                       input logic [4:0] a, input logic [4:0] b);
    sel = s; mem_data = md; alu_res = ar; rd = d; ena = e; pc = p;
    rs_addr = a; rt_addr = b;
  endtask

  task automatic check_trace();
    check("trace_wen",   {31'b0, debug_wb_rf_wen}, {31'b0, m_wen});
    check("trace_wnum",  {27'b0, debug_wb_rf_wnum}, {27'b0, m_wnum});
    check("trace_wdata", debug_wb_rf_wdata, m_wdata);
    check("trace_pc",    debug_wb_pc, m_pc);
    check("commit_cnt",  commit_cnt, m_cnt);
  endtask

  // Inputs are already driven (just after a falling edge): check reads, clock once, check trace.
  task automatic cycle();
    #1;
    check("wb_data", wb_data, m_wb());
    check("rs_data", rs_data, m_read(rs_addr));
    check("rt_data", rt_data, m_read(rt_addr));
    @(posedge clk);
    if (ena && rd != 5'd0) begin
      m_regs[rd] = m_wb();
      m_cnt      = m_cnt + 1;
    end
    m_wen   = ena && (rd != 5'd0);
    m_wnum  = rd;
    m_wdata = m_wb();
    m_pc    = pc;
    #1;
    check_trace();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);

    // Reset state: every index on both ports reads zero.
    #1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check("reset_rs", rs_data, 32'h0);
      check("reset_rt", rt_data, 32'h0);
    end
    check_trace();
    @(negedge clk);
    rst = 1'b0;

    // ALU result write to r5, visible next cycle.
    drive(1'b0, 32'hFFFF_0000, 32'h1234_5678, 5'd5, 1'b1, 32'h0040_0000, 5'd5, 5'd0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0040_0004, 5'd5, 5'd5);
    #1;
    check("r5_direct", rs_data, 32'h1234_5678);
    check("r5_wen",    {31'b0, debug_wb_rf_wen}, 32'h1);
    check("r5_wnum",   {27'b0, debug_wb_rf_wnum}, 32'd5);
    check("r5_wdata",  debug_wb_rf_wdata, 32'h1234_5678);
    check("r5_cnt",    commit_cnt, 32'd1);
    cycle();

    // Load data aimed at r0 is dropped.
    drive(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 32'h0040_0008, 5'd0, 5'd0);
    cycle();
    #1;
    check("r0_read", rs_data, 32'h0);
    check("r0_wen",  {31'b0, debug_wb_rf_wen}, 32'h0);
    check("r0_cnt",  commit_cnt, 32'd1);

    // Same-cycle read of the register being written.
    drive(1'b0, 32'h0, 32'h1111_2222, 5'd7, 1'b1, 32'h0040_000C, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 32'hA5A5_A5A5, 32'h0, 5'd7, 1'b1, 32'h0040_0010, 5'd7, 5'd7);
    #1;
`ifdef WB_BYPASS_EN
    check("byp_rs", rs_data, 32'hA5A5_A5A5);
    check("byp_rt", rt_data, 32'hA5A5_A5A5);
`else
    check("old_rs", rs_data, 32'h1111_2222);
    check("old_rt", rt_data, 32'h1111_2222);
`endif
    cycle();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0040_0014, 5'd7, 5'd7);
    #1;
    check("new_rs", rs_data, 32'hA5A5_A5A5);
    check("new_rt", rt_data, 32'hA5A5_A5A5);
    cycle();

    // Reset mid-cycle clears state immediately and discards the coincident write.
    drive(1'b0, 32'h0, 32'h0000_0001, 5'd3, 1'b1, 32'h0040_0018, 5'd3, 5'd5);
    cycle();
    drive(1'b0, 32'h0, 32'h0000_0001, 5'd3, 1'b1, 32'h0040_001C, 5'd3, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("rst_r3",  rs_data, 32'h0);
    check("rst_r5",  rt_data, 32'h0);
    check("rst_cnt", commit_cnt, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_r3",  rs_data, 32'h0);
    check("rst_edge_cnt", commit_cnt, 32'h0);
    check("rst_edge_wen", {31'b0, debug_wb_rf_wen}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic; reads biased towards the current destination.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive(1'($urandom), $urandom, $urandom, d, ($urandom_range(0, 3) != 0), $urandom,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      cycle();
    end

    // Counter wrap: preload the counter's next value, then commit one more write.
    drive(1'b0, 32'h0, 32'h0, 5'd9, 1'b0, 32'h0050_0000, 5'd0, 5'd0);
    force dut.commit_cnt_d = 32'hFFFF_FFFF;
    @(posedge clk);
    m_wen = 1'b0; m_wnum = 5'd9; m_wdata = 32'h0; m_pc = 32'h0050_0000;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt_d;
    check("cnt_max", commit_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 32'h0050_0004, 5'd9, 5'd0);
    cycle();
    check("cnt_wrap", commit_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
